lift_dispatch: RTL and testbench
================================

// Module: lift_dispatch
// PURPOSE
//  Car-control FSM for the 4-storey elevator; it is the initiator that drives the run and door timers.
//  Latches floor requests, picks travel direction (SCAN: keep direction while requests lie ahead).
//  Issues mv2nxt to the run timer and consumes endRun; issues opendoor to the door timer and consumes endOpen.
//  Tracks car floor and returns the car to HOME_FLOOR after an idle timeout.
// PARAMETERS
//  N_FLOORS     4    number of floors, indexed 0..N_FLOORS-1
//  FLOOR_W      2    floor index width, clog2(N_FLOORS)
//  HOME_FLOOR   0    idle return target
//  IDLE_RETURN  64   CP cycles idle with no request before homing; 0 = homing disabled
// PORTS
//  CP        in   1        system clock, all state on posedge CP
//  RST       in   1        async active-high reset
//  req       in   N_FLOORS per-floor request, level or pulse; bit i = floor i
//  endRun    in   1        run-timer done level; one floor travelled per rising edge
//  endOpen   in   1        door-timer done level; rising edge = door cycle complete
//  mv2nxt    out  1        run-timer enable; high for the whole of RUN
//  opendoor  out  1        door-timer enable; high for the whole of OPEN
//  dir       out  1        1 = up, 0 = down
//  floor     out  FLOOR_W  current car floor
//  pending   out  N_FLOORS latched, unserved requests
//  state     out  2        IDLE=0, RUN=1, OPEN=2
// BEHAVIOUR
//  Reset: state=IDLE, floor=0, dir=1, pending=0, mv2nxt=0, opendoor=0, idle counter=0. All outputs registered.
//  RST mid-RUN or mid-OPEN clears mv2nxt/opendoor immediately (async) and drops all pending requests.
//  Edge detect: endRun/endOpen are levels.
//    Each gets a 1-FF rising-edge detector, reset to 0; only rising edges act.
//  Latching: pending <= pending | req every cycle, with one exception:
//    a req bit for floor while state=OPEN is absorbed and never latched; the door timer is not restarted.
//  above = |pending[N-1:floor+1]; below = |pending[floor-1:0]. Both evaluated on pending|req.
//  IDLE (mv2nxt=0, opendoor=0):
//    pending[floor]                 -> OPEN, clear pending[floor]; 1-cycle latency from req to opendoor=1
//    else if above or below         -> RUN. Keep the current dir if its side has requests, else reverse.
//    else                           -> count idle cycles.
//      At IDLE_RETURN with floor!=HOME_FLOOR: set pending[HOME_FLOOR]. Counter clears on leaving IDLE.
//  RUN (mv2nxt=1):
//    on endRun rise                 -> floor <= floor +/- 1 per dir, saturated at 0 and N-1.
//    If (pending|req)[new floor]    -> OPEN next cycle: mv2nxt=0, opendoor=1, clear that bit.
//    else if requests remain in dir -> stay RUN, mv2nxt held 1.
//    else                           -> IDLE (re-decide; may reverse).
//    req arriving for the floor being passed on the same edge counts as a stop.
//  OPEN (opendoor=1):
//    on endOpen rise                -> IDLE, opendoor=0 next cycle. The next move starts no earlier than 1 cycle after that.
//    endOpen rise together with req[floor] -> req ignored, door closes.
//  mv2nxt and opendoor are never high together (one-hot with IDLE).
//  endRun outside RUN and endOpen outside OPEN are ignored.
//  Bench assertions:
//    floor never leaves 0..N-1;
//    dir changes only in IDLE;
//    no RUN entry with pending==0.
// STRUCTURE
//  Shared package elev_pkg: state localparams (IDLE/RUN/OPEN), N_FLOORS, FLOOR_W, DIR_UP/DIR_DN.
//  Sub-module rise_det (1-bit registered rising-edge detector, async RST), instantiated twice.
//  Top: request latch, direction/stop logic, 3-state FSM, idle counter.
// TESTING
//  1 RST, req=4'b0001 pulse at floor 0 -> opendoor=1 next cycle.
//    endOpen rise -> IDLE, pending=0.
//  2 floor 0, req=4'b1000 -> RUN, dir=1, mv2nxt=1.
//    3 endRun rises -> floor 3, then OPEN, pending[3]=0, mv2nxt=0.
//  3 floor 0, req=4'b1000, then req[1] just before the first endRun rise -> stop at floor 1 (OPEN).
//    After endOpen rise: RUN up to floor 3.
//  4 floor 3, dir=1, pending=4'b0011 -> IDLE reverses: dir=0, stops at floor 1 then floor 0.
//  5 OPEN at floor 2, req[2] pulses, including a pulse in the same cycle as the endOpen rise -> pending[2] stays 0, no reopen.
//  6 Idle at floor 2, no req for IDLE_RETURN=64 cycles -> pending[0] set, car homes to floor 0, dir=0.
//  7 RST asserted mid-RUN at floor 1 -> mv2nxt=0 immediately; state=IDLE, floor=0, pending=0.

Source files
------------

// File: rtl/elev_pkg.sv
// Shared elevator definitions: car FSM states, building size and direction codes.
// Imported by lift_dispatch and its helpers.
package elev_pkg;

  localparam int unsigned N_FLOORS = 4;
  localparam int unsigned FLOOR_W  = 2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OPEN = 2'd2
  } state_t;

endpackage

// File: rtl/lift_dispatch_rise_det.sv
// rise_det: 1-bit rising-edge detector for level done signals.
// Ports:
//   CP   - clock
//   RST  - async active-high reset; clears the history FF
//   din  - level input
//   rise - high during the cycle where din is 1 and was 0 at the previous edge
module rise_det (
  input  logic CP,
  input  logic RST,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge CP or posedge RST) begin
    if (RST) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/lift_dispatch.sv
// lift_dispatch: car-control FSM for the elevator. Latches floor requests,
// chooses direction with SCAN, drives the run timer (mv2nxt) and door timer
// (opendoor), tracks the car floor and homes the car after an idle timeout.
// Ports:
//   CP, RST   - clock, async active-high reset
//   req       - per-floor request (level or pulse)
//   endRun    - run-timer done level, one floor per rising edge
//   endOpen   - door-timer done level, rising edge ends the door cycle
//   mv2nxt    - run-timer enable, high throughout RUN
//   opendoor  - door-timer enable, high throughout OPEN
//   dir       - 1 = up, 0 = down
//   floor     - current car floor
//   pending   - latched, unserved requests
//   state     - IDLE=0, RUN=1, OPEN=2
module lift_dispatch
  import elev_pkg::*;
#(
  parameter int unsigned HOME_FLOOR  = 0,
  parameter int unsigned IDLE_RETURN = 64
) (
  input  logic                CP,
  input  logic                RST,
  input  logic [N_FLOORS-1:0] req,
  input  logic                endRun,
  input  logic                endOpen,
  output logic                mv2nxt,
  output logic                opendoor,
  output logic                dir,
  output logic [FLOOR_W-1:0]  floor,
  output logic [N_FLOORS-1:0] pending,
  output logic [1:0]          state
);

  localparam int unsigned CNT_W = (IDLE_RETURN > 1) ? $clog2(IDLE_RETURN) : 1;

  state_t              st;
  logic                run_rise;
  logic                open_rise;
  logic [N_FLOORS-1:0] req_eff;
  logic [N_FLOORS-1:0] pr;
  logic [FLOOR_W-1:0]  next_floor;
  logic                above;
  logic                below;
  logic                ahead_next;
  logic [CNT_W-1:0]    idle_cnt;

  // Any request strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic any_side(input logic [N_FLOORS-1:0] v,
                                    input logic [FLOOR_W-1:0]  f,
                                    input logic                up);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (v[i] && (up ? (i > 32'(f)) : (i < 32'(f)))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [N_FLOORS-1:0] bit_of(input logic [FLOOR_W-1:0] f);
    logic [N_FLOORS-1:0] b;
    b    = '0;
    b[f] = 1'b1;
    return b;
  endfunction

  rise_det u_run_det (
    .CP   (CP),
    .RST  (RST),
    .din  (endRun),
    .rise (run_rise)
  );

  rise_det u_open_det (
    .CP   (CP),
    .RST  (RST),
    .din  (endOpen),
    .rise (open_rise)
  );

  always_comb begin
    // A call for the floor whose door is already open is absorbed.
    req_eff = req;
    if (st == OPEN) req_eff[floor] = 1'b0;
    pr    = pending | req_eff;
    above = any_side(pr, floor, DIR_UP);
    below = any_side(pr, floor, DIR_DN);
    if (dir == DIR_UP)
      next_floor = (floor == FLOOR_W'(N_FLOORS - 1)) ? floor : floor + FLOOR_W'(1);
    else
      next_floor = (floor == '0) ? floor : floor - FLOOR_W'(1);
    ahead_next = any_side(pr, next_floor, dir);
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      st       <= IDLE;
      floor    <= '0;
      dir      <= DIR_UP;
      pending  <= '0;
      mv2nxt   <= 1'b0;
      opendoor <= 1'b0;
      idle_cnt <= '0;
    end else begin
      pending <= pr;
      case (st)
        IDLE: begin
          if (pr[floor]) begin
            st       <= OPEN;
            opendoor <= 1'b1;
            pending  <= pr & ~bit_of(floor);
            idle_cnt <= '0;
          end else if (above || below) begin
            st       <= RUN;
            mv2nxt   <= 1'b1;
            idle_cnt <= '0;
            if (dir == DIR_UP) dir <= above ? DIR_UP : DIR_DN;
            else               dir <= below ? DIR_DN : DIR_UP;
          end else if (IDLE_RETURN != 0 && floor != FLOOR_W'(HOME_FLOOR)) begin
            if (idle_cnt == CNT_W'(IDLE_RETURN - 1)) begin
              pending[HOME_FLOOR] <= 1'b1;
              idle_cnt            <= '0;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        RUN: begin
          if (run_rise) begin
            floor <= next_floor;
            // pr already includes a request arriving on this edge, so it stops the car.
            if (pr[next_floor]) begin
              st       <= OPEN;
              mv2nxt   <= 1'b0;
              opendoor <= 1'b1;
              pending  <= pr & ~bit_of(next_floor);
            end else if (!ahead_next) begin
              st     <= IDLE;
              mv2nxt <= 1'b0;
            end
          end
        end
        OPEN: begin
          if (open_rise) begin
            st       <= IDLE;
            opendoor <= 1'b0;
          end
        end
        default: begin
          st       <= IDLE;
          mv2nxt   <= 1'b0;
          opendoor <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_lift_dispatch.sv
// Directed self-checking bench for lift_dispatch with hand-computed expectations.
module tb_lift_dispatch;

  logic       CP;
  logic       RST;
  logic [3:0] req;
  logic       endRun;
  logic       endOpen;
  logic       mv2nxt;
  logic       opendoor;
  logic       dir;
  logic [1:0] floor;
  logic [3:0] pending;
  logic [1:0] state;

  int n_chk;
  int n_err;

  logic [1:0] prev_state;
  logic       prev_dir;

  lift_dispatch #(
    .HOME_FLOOR  (0),
    .IDLE_RETURN (64)
  ) dut (
    .CP       (CP),
    .RST      (RST),
    .req      (req),
    .endRun   (endRun),
    .endOpen  (endOpen),
    .mv2nxt   (mv2nxt),
    .opendoor (opendoor),
    .dir      (dir),
    .floor    (floor),
    .pending  (pending),
    .state    (state)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req = v;
    cyc(1);
    req = '0;
  endtask

  task automatic run_step();
    endRun = 1'b1;
    cyc(1);
    endRun = 1'b0;
    cyc(1);
  endtask

  task automatic door_close();
    endOpen = 1'b1;
    cyc(1);
    endOpen = 1'b0;
    cyc(1);
  endtask

  // Continuous invariants sampled on the falling edge.
  always @(negedge CP) begin
    if (!RST) begin
      check("onehot", 32'(mv2nxt & opendoor), 0);
      check("floor_rng", 32'(floor < 2'd3 || floor == 2'd3), 1);
      if (prev_state != 2'd0) check("dir_hold", 32'(dir), 32'(prev_dir));
      if (state == 2'd1 && prev_state == 2'd0) check("run_entry", 32'(pending != 4'd0), 1);
    end
    prev_state = state;
    prev_dir   = dir;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    RST = 1'b1; req = '0; endRun = 1'b0; endOpen = 1'b0;
    cyc(2);
    RST = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_floor", 32'(floor), 0);
    check("rst_dir", 32'(dir), 1);
    check("rst_pend", 32'(pending), 0);
    check("rst_mv", 32'(mv2nxt), 0);
    check("rst_door", 32'(opendoor), 0);

    // endRun outside RUN does nothing
    run_step();
    check("stray_run_st", 32'(state), 0);
    check("stray_run_fl", 32'(floor), 0);

    // 1: call at current floor opens next cycle
    pulse_req(4'b0001);
    check("t1_door", 32'(opendoor), 1);
    check("t1_state", 32'(state), 2);
    check("t1_pend", 32'(pending), 0);
    door_close();
    check("t1_idle", 32'(state), 0);
    check("t1_door0", 32'(opendoor), 0);
    check("t1_pend0", 32'(pending), 0);

    // 2: run 0 -> 3
    pulse_req(4'b1000);
    check("t2_state", 32'(state), 1);
    check("t2_dir", 32'(dir), 1);
    check("t2_mv", 32'(mv2nxt), 1);
    run_step();
    check("t2_f1", 32'(floor), 1);
    check("t2_run1", 32'(state), 1);
    run_step();
    check("t2_f2", 32'(floor), 2);
    run_step();
    check("t2_f3", 32'(floor), 3);
    check("t2_open", 32'(state), 2);
    check("t2_mv0", 32'(mv2nxt), 0);
    check("t2_door", 32'(opendoor), 1);
    check("t2_pend", 32'(pending), 0);
    door_close();
    check("t2_idle", 32'(state), 0);

    // 4: at floor 3 going up, calls below reverse the car
    pulse_req(4'b0011);
    check("t4_state", 32'(state), 1);
    check("t4_dir", 32'(dir), 0);
    run_step();
    check("t4_f2", 32'(floor), 2);
    check("t4_run", 32'(state), 1);
    run_step();
    check("t4_f1", 32'(floor), 1);
    check("t4_open1", 32'(state), 2);
    check("t4_pend1", 32'(pending), 4'b0001);
    door_close();
    check("t4_rerun", 32'(state), 1);
    check("t4_dir2", 32'(dir), 0);
    run_step();
    check("t4_f0", 32'(floor), 0);
    check("t4_open0", 32'(opendoor), 1);
    check("t4_pend0", 32'(pending), 0);
    door_close();
    check("t4_idle", 32'(state), 0);

    // 3: stop at floor 1 for a call arriving on the same edge as the first endRun rise
    pulse_req(4'b1000);
    check("t3_state", 32'(state), 1);
    check("t3_dir", 32'(dir), 1);
    req = 4'b0010;
    endRun = 1'b1;
    cyc(1);
    req = '0;
    endRun = 1'b0;
    cyc(1);
    check("t3_f1", 32'(floor), 1);
    check("t3_open", 32'(state), 2);
    check("t3_pend", 32'(pending), 4'b1000);
    door_close();
    check("t3_rerun", 32'(state), 1);
    check("t3_dir2", 32'(dir), 1);
    run_step();
    check("t3_f2", 32'(floor), 2);
    run_step();
    check("t3_f3", 32'(floor), 3);
    check("t3_door", 32'(opendoor), 1);
    door_close();

    // 5: calls for the open floor are absorbed, including with the endOpen rise
    pulse_req(4'b0100);
    check("t5_dir", 32'(dir), 0);
    run_step();
    check("t5_f2", 32'(floor), 2);
    check("t5_open", 32'(state), 2);
    pulse_req(4'b0100);
    check("t5_absorb", 32'(pending), 0);
    check("t5_still", 32'(state), 2);
    req = 4'b0100;
    endOpen = 1'b1;
    cyc(1);
    req = '0;
    endOpen = 1'b0;
    check("t5_close", 32'(state), 0);
    check("t5_pend", 32'(pending), 0);
    cyc(2);
    check("t5_noreopen", 32'(state), 0);
    check("t5_door0", 32'(opendoor), 0);

    // 6: idle timeout at floor 2 homes the car (64th idle edge sets pending[0])
    cyc(60);
    check("t6_early", 32'(pending), 0);
    cyc(2);
    check("t6_home_req", 32'(pending), 4'b0001);
    check("t6_idle", 32'(state), 0);
    cyc(1);
    check("t6_run", 32'(state), 1);
    check("t6_dir", 32'(dir), 0);
    run_step();
    check("t6_f1", 32'(floor), 1);
    run_step();
    check("t6_f0", 32'(floor), 0);
    check("t6_open", 32'(state), 2);
    door_close();

    // 7: async reset mid-RUN at floor 1
    pulse_req(4'b1000);
    run_step();
    check("t7_f1", 32'(floor), 1);
    check("t7_mv", 32'(mv2nxt), 1);
    RST = 1'b1;
    #1;
    check("t7_mv0", 32'(mv2nxt), 0);
    check("t7_state", 32'(state), 0);
    check("t7_floor", 32'(floor), 0);
    check("t7_pend", 32'(pending), 0);
    cyc(1);
    RST = 1'b0;
    cyc(2);
    check("t7_idle", 32'(state), 0);
    check("t7_pend2", 32'(pending), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
